// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
// Transfer happens when o_imem_req & i_imem_gnt; rvalid returns 1+ cycles later.
interface instr_fetch_unit_if;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;

  modport master (
    output o_imem_req, o_imem_addr,
    input  i_imem_gnt, i_imem_rvalid, i_imem_rdata
  );

  modport slave (
    input  o_imem_req, o_imem_addr,
    output i_imem_gnt, i_imem_rvalid, i_imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch unit: issues word fetches, buffers one
// instruction for decode, and squashes in-flight responses on redirect.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                       clk,
  input  logic                       reset,
  instr_fetch_unit_if.master         imem,
  input  logic                       i_stall,
  input  logic                       i_redirect,
  input  logic [31:0]                i_redirect_pc,
  output logic [31:0]                o_inst,
  output logic [31:0]                o_PC,
  output logic [31:0]                o_PC_plus_4,
  output logic                       o_valid
);

  typedef enum logic {S_REQ, S_WAIT} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] pend_pc;
  logic        drop_q;

  logic        transfer;
  logic        resp;
  logic        consume;
  logic [31:0] redirect_tgt;
  logic        unused_redirect_lsbs;

  assign redirect_tgt         = {i_redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^i_redirect_pc[1:0];

  // Request only when the output slot is free or being drained this cycle,
  // so a returning instruction always has somewhere to land.
  assign imem.o_imem_req  = (state_q == S_REQ) & ~i_redirect & (~o_valid | ~i_stall);
  assign imem.o_imem_addr = pc_q;

  assign transfer = imem.o_imem_req & imem.i_imem_gnt;
  assign resp     = (state_q == S_WAIT) & imem.i_imem_rvalid;
  assign consume  = o_valid & ~i_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      pend_pc     <= '0;
      drop_q      <= 1'b0;
      o_valid     <= 1'b0;
      o_inst      <= '0;
      o_PC        <= '0;
      o_PC_plus_4 <= '0;
    end else if (i_redirect) begin
      o_valid <= 1'b0;
      pc_q    <= redirect_tgt;
      if (state_q == S_WAIT) begin
        // A response landing with the redirect is simply discarded; otherwise
        // remember to discard the one still in flight.
        if (resp) begin
          drop_q  <= 1'b0;
          state_q <= S_REQ;
        end else begin
          drop_q  <= 1'b1;
        end
      end
    end else begin
      if (consume) o_valid <= 1'b0;
      if (state_q == S_REQ) begin
        if (transfer) begin
          pend_pc <= pc_q;
          pc_q    <= pc_q + 32'd4;
          state_q <= S_WAIT;
        end
      end else if (resp) begin
        state_q <= S_REQ;
        drop_q  <= 1'b0;
        if (!drop_q) begin
          o_inst      <= imem.i_imem_rdata;
          o_PC        <= pend_pc;
          o_PC_plus_4 <= pend_pc + 32'd4;
          o_valid     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + randomized bench for instr_fetch_unit with a transaction-level
// reference model (expected fetch stream, outstanding fetch, output slot).
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] o_inst, o_PC, o_PC_plus_4;
  logic        o_valid;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem          (bus),
    .i_stall       (stall),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_inst        (o_inst),
    .o_PC          (o_PC),
    .o_PC_plus_4   (o_PC_plus_4),
    .o_valid       (o_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // memory environment
  int          gnt_mode;   // 0: never grant, 1: always grant, else random
  int          lat_rand;
  int          mem_lat;
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;

  // reference model
  logic        m_valid;
  logic [31:0] m_inst, m_pc, m_pc4;
  logic [31:0] m_next;
  logic        m_busy, m_killed;
  logic [31:0] m_faddr;

  // snapshot of the last sampled cycle for directed checks
  logic        cap_req, cap_valid;
  logic [31:0] cap_addr, cap_pc, cap_pc4, cap_inst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mem_drive();
    if (mem_busy && mem_cnt == 0) begin
      bus.i_imem_rvalid = 1'b1;
      bus.i_imem_rdata  = mem_addr ^ KEY;
      mem_busy          = 1'b0;
    end else begin
      if (mem_busy) mem_cnt--;
      bus.i_imem_rvalid = 1'b0;
      bus.i_imem_rdata  = $urandom;
    end
    case (gnt_mode)
      0:       bus.i_imem_gnt = 1'b0;
      1:       bus.i_imem_gnt = 1'b1;
      default: bus.i_imem_gnt = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic sample();
    logic exp_req;
    logic load;
    cap_req   = bus.o_imem_req;
    cap_addr  = bus.o_imem_addr;
    cap_valid = o_valid;
    cap_pc    = o_PC;
    cap_pc4   = o_PC_plus_4;
    cap_inst  = o_inst;
    if (reset) begin
      chk("rst_valid", 32'(o_valid), 0);
      chk("rst_pc", o_PC, 0);
      chk("rst_pc4", o_PC_plus_4, 0);
      chk("rst_inst", o_inst, 0);
      chk("rst_addr", bus.o_imem_addr, RESET_PC);
      m_valid = 1'b0; m_inst = '0; m_pc = '0; m_pc4 = '0;
      m_next = RESET_PC; m_busy = 1'b0; m_killed = 1'b0;
    end else begin
      chk("valid", 32'(o_valid), 32'(m_valid));
      chk("pc", o_PC, m_pc);
      chk("pc4", o_PC_plus_4, m_pc4);
      chk("inst", o_inst, m_inst);
      exp_req = !m_busy && !redirect && (!m_valid || !stall);
      chk("req", 32'(bus.o_imem_req), 32'(exp_req));
      if (exp_req) chk("addr", bus.o_imem_addr, m_next);

      load = 1'b0;
      if (bus.i_imem_rvalid && m_busy) begin
        m_busy = 1'b0;
        load   = !m_killed && !redirect;
      end
      if (exp_req && bus.i_imem_gnt) begin
        m_busy   = 1'b1;
        m_killed = 1'b0;
        m_faddr  = m_next;
        m_next   = m_next + 32'd4;
      end
      if (redirect) begin
        m_next = {redirect_pc[31:2], 2'b00};
        if (m_busy) m_killed = 1'b1;
        m_valid = 1'b0;
      end else if (load) begin
        m_valid = 1'b1;
        m_pc    = m_faddr;
        m_pc4   = m_faddr + 32'd4;
        m_inst  = m_faddr ^ KEY;
      end else if (m_valid && !stall) begin
        m_valid = 1'b0;
      end
    end
    if (!reset && bus.o_imem_req && bus.i_imem_gnt) begin
      mem_busy = 1'b1;
      mem_addr = bus.o_imem_addr;
      mem_cnt  = (lat_rand != 0 ? int'($urandom_range(1, 4)) : mem_lat) - 1;
    end
  endtask

  task step();
    mem_drive();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    gnt_mode = 1; lat_rand = 0; mem_lat = 1; mem_busy = 1'b0; mem_cnt = 0; mem_addr = '0;
    bus.i_imem_gnt = 1'b0; bus.i_imem_rvalid = 1'b0; bus.i_imem_rdata = '0;
    m_valid = 1'b0; m_inst = '0; m_pc = '0; m_pc4 = '0; m_next = RESET_PC;
    m_busy = 1'b0; m_killed = 1'b0; m_faddr = '0;
    step(); step();

    // straight fetch, 1-cycle memory
    reset = 1'b0;
    step(); chk("c0_req", 32'(cap_req), 1); chk("c0_addr", cap_addr, 32'h3000);
    step(); chk("c1_req", 32'(cap_req), 0); chk("c1_valid", 32'(cap_valid), 0);
    step(); chk("c2_valid", 32'(cap_valid), 1); chk("c2_pc", cap_pc, 32'h3000);
    chk("c2_pc4", cap_pc4, 32'h3004); chk("c2_inst", cap_inst, 32'hA5A5_3000);
    chk("c2_addr", cap_addr, 32'h3004);
    step(); chk("c3_valid", 32'(cap_valid), 0);

    // stall hold
    stall = 1'b1;
    step(); chk("c4_pc", cap_pc, 32'h3004); chk("c4_req", 32'(cap_req), 0);
    step(); step();
    chk("c6_valid", 32'(cap_valid), 1); chk("c6_inst", cap_inst, 32'hA5A5_3004);
    chk("c6_pc4", cap_pc4, 32'h3008); chk("c6_req", 32'(cap_req), 0);
    stall = 1'b0; mem_lat = 3;
    step(); chk("c7_req", 32'(cap_req), 1); chk("c7_addr", cap_addr, 32'h3008);

    // redirect while waiting: in-flight 3008 must be dropped
    redirect = 1'b1; redirect_pc = 32'h0000_4002;
    step(); chk("c8_req", 32'(cap_req), 0);
    redirect = 1'b0;
    step(); chk("c9_valid", 32'(cap_valid), 0);
    step(); chk("c10_req", 32'(cap_req), 0);
    mem_lat = 1;
    step(); chk("c11_valid", 32'(cap_valid), 0); chk("c11_addr", cap_addr, 32'h4000);
    chk("c11_req", 32'(cap_req), 1);

    // redirect coincident with rvalid
    redirect = 1'b1; redirect_pc = 32'h0000_5000;
    step();
    redirect = 1'b0; gnt_mode = 0;
    step(); chk("c13_valid", 32'(cap_valid), 0); chk("c13_addr", cap_addr, 32'h5000);

    // wrap with grant backpressure
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0;
    step(); chk("c15_addr", cap_addr, 32'hFFFF_FFFC);
    step(); chk("c16_addr", cap_addr, 32'hFFFF_FFFC); chk("c16_req", 32'(cap_req), 1);
    gnt_mode = 1;
    step(); step();
    mem_lat = 3;
    step(); chk("c19_pc", cap_pc, 32'hFFFF_FFFC); chk("c19_pc4", cap_pc4, 32'h0000_0000);
    chk("c19_addr", cap_addr, 32'h0000_0000);

    // reset while waiting; stale response arrives after release
    reset = 1'b1;
    step();
    reset = 1'b0; gnt_mode = 0;
    step(); chk("c21_addr", cap_addr, RESET_PC);
    step(); chk("c22_valid", 32'(cap_valid), 0);
    gnt_mode = 1;
    step(); chk("c23_valid", 32'(cap_valid), 0); chk("c23_addr", cap_addr, RESET_PC);

    // randomized traffic against the reference model
    gnt_mode = 2; lat_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      stall    = ($urandom_range(0, 9) < 3);
      redirect = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else                           redirect_pc = $urandom;
      step();
    end
    stall = 1'b0; redirect = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
